// File: rtl/ps2_cpc_pkg.sv
// Shared definitions for the PS/2 to CPC keyboard bridge: rx FSM states,
// special scancodes and the set-2 to CPC matrix mapping table.
package ps2_cpc_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_EE = 8'hEE;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_FF = 8'hFF;

  localparam int ROWS = 10;
  localparam int COLS = 8;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } key_map_t;

  function automatic key_map_t hit(input int row, input int col);
    return '{valid: 1'b1, row: 4'(row), col: 3'(col)};
  endfunction

  // Index is {ext, code}; ext selects the E0-prefixed code space.
  function automatic key_map_t map_code(input logic [8:0] key);
    key_map_t m;
    m = '{valid: 1'b0, row: 4'd0, col: 3'd0};
    case (key)
      {1'b0, 8'h1C}: m = hit(8, 5);
      {1'b0, 8'h29}: m = hit(5, 7);
      {1'b0, 8'h5A}: m = hit(2, 2);
      {1'b0, 8'h12}: m = hit(2, 5);
      {1'b0, 8'h59}: m = hit(2, 5);
      {1'b0, 8'h76}: m = hit(8, 2);
      {1'b1, 8'h75}: m = hit(0, 0);
      {1'b1, 8'h72}: m = hit(0, 2);
      {1'b1, 8'h6B}: m = hit(1, 0);
      {1'b1, 8'h74}: m = hit(0, 1);
      {1'b0, 8'h14}: m = hit(2, 7);
      {1'b0, 8'h66}: m = hit(9, 7);
      default:       m = '{valid: 1'b0, row: 4'd0, col: 3'd0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter,
// 11-bit frame FSM with odd-parity check and inter-edge timeout.
module ps2_rx
  import ps2_cpc_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic          filt_p2, fall_p2;
  logic [FW-1:0] filt_cnt;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          timeout, shift_en, par_en, done_ok, done_err;

  // p0/p1: two-flop synchronisers
  always_ff @(posedge clk) begin
    dat_p0 <= ps2_dat;
    dat_p1 <= dat_p0;
  end

  // p2: filtered clock changes only after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0   <= 1'b1;
      clk_p1   <= 1'b1;
      filt_p2  <= 1'b1;
      filt_cnt <= '0;
      fall_p2  <= 1'b0;
    end else begin
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      fall_p2 <= 1'b0;
      if (clk_p1 == filt_p2) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_p2  <= clk_p1;
        filt_cnt <= '0;
        fall_p2  <= ~clk_p1;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout = (state != RX_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    par_en   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    if (timeout) begin
      state_n  = RX_IDLE;
      done_err = 1'b1;
    end else if (fall_p2) begin
      case (state)
        RX_IDLE: if (!dat_p1) state_n = RX_DATA;
        RX_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          par_en  = 1'b1;
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          if (dat_p1 && (^{shift, par})) done_ok = 1'b1;
          else done_err = 1'b1;
        end
        default: state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift <= {dat_p1, shift[7:1]};
    if (par_en)   par   <= dat_p1;
  end

  // p3: frame control and registered result strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
      rx_byte    <= '0;
    end else begin
      state      <= state_n;
      byte_valid <= done_ok;
      err        <= done_err;
      if (done_ok) rx_byte <= shift;
      if (state == RX_IDLE) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
      if (fall_p2) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_cpc_keyboard.sv
// PS/2 set-2 keyboard to CPC 80-bit active-low key matrix. Prefix flags
// (E0 extended, F0 break) qualify the next non-prefix scancode.
module ps2_cpc_keyboard
  import ps2_cpc_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  input  logic        clear_i,
  output logic [79:0] keyboard_o,
  output logic        scan_valid_o,
  output logic [7:0]  scan_code_o,
  output logic        frame_err_o
);

  logic                   byte_valid, err;
  logic [7:0]             rx_byte;
  logic                   ext, brk;
  logic [ROWS*COLS-1:0]   keys;
  key_map_t               key;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk_i),
    .rst       (reset_i),
    .ps2_clk   (ps2_clk_i),
    .ps2_dat   (ps2_dat_i),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .err       (err)
  );

  assign key = map_code({ext, rx_byte});

  // Matrix stage: one cycle after byte_valid; clear overrides any update
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      keys <= '1;
      ext  <= 1'b0;
      brk  <= 1'b0;
    end else if (byte_valid) begin
      case (rx_byte)
        CODE_E0: ext <= 1'b1;
        CODE_F0: brk <= 1'b1;
        CODE_E1, CODE_AA, CODE_FA, CODE_FE, CODE_EE, CODE_00, CODE_FF: begin
        end
        default: begin
          if (key.valid) keys[{key.row, key.col}] <= brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

  assign keyboard_o   = keys;
  assign scan_valid_o = byte_valid;
  assign scan_code_o  = rx_byte;
  assign frame_err_o  = err;

endmodule

// File: tb/tb_ps2_cpc_keyboard.sv
// Bench for ps2_cpc_keyboard: table of scancode sequences with expected
// matrices, a scoreboard for received bytes/errors, and corner sequences.
module tb_ps2_cpc_keyboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        clear = 1'b0;
  logic [79:0] keyboard;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int SLOW = 640;
  localparam int FAST = 30;
  localparam int NVEC = 22;
  localparam logic [79:0] ONES = '1;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
  } sb_t;

  typedef struct packed {
    logic        slow;
    logic [1:0]  n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [79:0] exp_kb;
  } vec_t;

  sb_t  exp_q[$];
  sb_t  mon_e;
  vec_t vecs[NVEC];

  always #31 clk = ~clk;

  ps2_cpc_keyboard dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .clear_i     (clear),
    .keyboard_o  (keyboard),
    .scan_valid_o(scan_valid),
    .scan_code_o (scan_code),
    .frame_err_o (frame_err)
  );

  function automatic logic [79:0] kb1(input int bit_idx);
    return ONES & ~(80'd1 << bit_idx);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Frame bits LSB first: start, 8 data, odd parity, stop.
  task automatic send_bits(input logic [7:0] b, input int half, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      idle(half);
      ps2_clk = 1'b0;
      idle(half);
      ps2_clk = 1'b1;
    end
    idle(half);
    ps2_dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    exp_q.push_back('{err: 1'b0, code: b});
    send_bits(b, half, 1'b0, 11);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Scoreboard: every scan_valid/frame_err pulse must match the next expectation.
  always @(negedge clk) begin
    if (scan_valid || frame_err) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got valid=%0b err=%0b code=%h, expected no event",
                 scan_valid, frame_err, scan_code);
      end else begin
        mon_e = exp_q.pop_front();
        if ((frame_err !== mon_e.err) || (scan_valid === mon_e.err) ||
            (!mon_e.err && (scan_code !== mon_e.code))) begin
          n_fail++;
          $display("FAIL sb_event: got valid=%0b err=%0b code=%h, expected err=%0b code=%h",
                   scan_valid, frame_err, scan_code, mon_e.err, mon_e.code);
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 2'd1, 8'h1C, 8'h00, 8'h00, kb1(69)};
    vecs[1]  = '{1'b0, 2'd2, 8'hF0, 8'h1C, 8'h00, ONES};
    vecs[2]  = '{1'b0, 2'd2, 8'hE0, 8'h75, 8'h00, kb1(0)};
    vecs[3]  = '{1'b0, 2'd1, 8'h1C, 8'h00, 8'h00, kb1(0) & kb1(69)};
    vecs[4]  = '{1'b0, 2'd3, 8'hE0, 8'hF0, 8'h75, kb1(69)};
    vecs[5]  = '{1'b0, 2'd2, 8'hF0, 8'h1C, 8'h00, ONES};
    vecs[6]  = '{1'b0, 2'd1, 8'h12, 8'h00, 8'h00, kb1(21)};
    vecs[7]  = '{1'b0, 2'd1, 8'h59, 8'h00, 8'h00, kb1(21)};
    vecs[8]  = '{1'b0, 2'd2, 8'hF0, 8'h59, 8'h00, ONES};
    vecs[9]  = '{1'b0, 2'd3, 8'hE0, 8'hAA, 8'h75, kb1(0)};
    vecs[10] = '{1'b0, 2'd3, 8'hE0, 8'hF0, 8'h75, ONES};
    vecs[11] = '{1'b0, 2'd2, 8'hE0, 8'h1C, 8'h00, ONES};
    vecs[12] = '{1'b0, 2'd1, 8'h1C, 8'h00, 8'h00, kb1(69)};
    vecs[13] = '{1'b0, 2'd2, 8'hF0, 8'h1C, 8'h00, ONES};
    vecs[14] = '{1'b0, 2'd2, 8'hE0, 8'h74, 8'h00, kb1(1)};
    vecs[15] = '{1'b0, 2'd1, 8'h66, 8'h00, 8'h00, kb1(1) & kb1(79)};
    vecs[16] = '{1'b0, 2'd1, 8'h14, 8'h00, 8'h00, kb1(1) & kb1(79) & kb1(23)};
    vecs[17] = '{1'b0, 2'd1, 8'h76, 8'h00, 8'h00, kb1(1) & kb1(79) & kb1(23) & kb1(66)};
    vecs[18] = '{1'b0, 2'd2, 8'hE0, 8'h6B, 8'h00, kb1(1) & kb1(79) & kb1(23) & kb1(66) & kb1(8)};
    vecs[19] = '{1'b0, 2'd2, 8'hE0, 8'h72, 8'h00, kb1(1) & kb1(79) & kb1(23) & kb1(66) & kb1(8) & kb1(2)};
    vecs[20] = '{1'b0, 2'd1, 8'h5A, 8'h00, 8'h00,
                 kb1(1) & kb1(79) & kb1(23) & kb1(66) & kb1(8) & kb1(2) & kb1(18)};
    vecs[21] = '{1'b0, 2'd1, 8'h29, 8'h00, 8'h00,
                 kb1(1) & kb1(79) & kb1(23) & kb1(66) & kb1(8) & kb1(2) & kb1(18) & kb1(47)};

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_kb", keyboard, ONES);
    check("reset_valid", 80'(scan_valid), 80'd0);
    check("reset_err", 80'(frame_err), 80'd0);
    check("reset_code", 80'(scan_code), 80'd0);

    for (int i = 0; i < NVEC; i++) begin
      int half;
      half = vecs[i].slow ? SLOW : FAST;
      send_byte(vecs[i].b0, half);
      if (vecs[i].n >= 2'd2) send_byte(vecs[i].b1, half);
      if (vecs[i].n >= 2'd3) send_byte(vecs[i].b2, half);
      @(negedge clk);
      check($sformatf("vec%0d", i), keyboard, vecs[i].exp_kb);
    end

    pulse_clear();
    check("clear_all", keyboard, ONES);

    // Pending break must be dropped by clear.
    send_byte(8'hF0, FAST);
    pulse_clear();
    send_byte(8'h1C, FAST);
    @(negedge clk);
    check("clear_drops_brk", keyboard, kb1(69));
    send_byte(8'hF0, FAST);
    send_byte(8'h1C, FAST);
    @(negedge clk);
    check("clear_brk_release", keyboard, ONES);

    // Parity error.
    exp_q.push_back('{err: 1'b1, code: 8'h00});
    send_bits(8'h29, FAST, 1'b1, 11);
    @(negedge clk);
    check("parity_kb", keyboard, ONES);
    send_byte(8'h29, FAST);
    @(negedge clk);
    check("parity_recover", keyboard, kb1(47));
    send_byte(8'hF0, FAST);
    send_byte(8'h29, FAST);

    // Timeout on a partial frame.
    exp_q.push_back('{err: 1'b1, code: 8'h00});
    send_bits(8'h12, FAST, 1'b0, 4);
    idle(16100);
    check("timeout_err", 80'(exp_q.size()), 80'd0);
    send_byte(8'h12, FAST);
    @(negedge clk);
    check("timeout_recover", keyboard, kb1(21));

    // Clear coinciding with a matrix update.
    send_byte(8'h5A, FAST);
    @(negedge clk);
    check("two_held", keyboard, kb1(21) & kb1(18));
    fork
      send_byte(8'h76, FAST);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!scan_valid && k < 2000) begin
          @(negedge clk);
          k++;
        end
        if (!scan_valid) begin
          n_tests++;
          n_fail++;
          $display("FAIL clear_sync_wait: got no scan_valid in 2000 cycles, expected one");
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
    join
    @(negedge clk);
    check("clear_wins", keyboard, ONES);
    send_byte(8'h1C, FAST);
    @(negedge clk);
    check("rx_after_clear", keyboard, kb1(69));
    send_byte(8'hF0, FAST);
    send_byte(8'h1C, FAST);

    // Short glitch on the PS/2 clock while data is low.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    idle(20);
    send_byte(8'h1C, FAST);
    @(negedge clk);
    check("glitch_ignored", keyboard, kb1(69));

    // Reset in the middle of a frame: no error, matrix back to released.
    send_bits(8'h76, FAST, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midframe_reset_kb", keyboard, ONES);
    send_byte(8'h1C, FAST);
    @(negedge clk);
    check("after_reset_frame", keyboard, kb1(69));
    send_byte(8'hF0, FAST);
    send_byte(8'h1C, FAST);
    @(negedge clk);
    check("after_reset_release", keyboard, ONES);

    idle(100);
    check("sb_drained", 80'(exp_q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
